// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered-output ALU between two requesters,
// returning result, overflow, error and requester ID over a valid/ready response channel.
module alu_req_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [3:0]        r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [17:0]       r0_aux,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [3:0]        r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [17:0]       r1_aux,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [5:0]        alu_sub_start,
  output logic [5:0]        alu_sub_len,
  output logic [5:0]        alu_shift_amt,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_q;
  logic              idle, grant0, grant1, accept, sel, sel_illegal;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [17:0]       sel_aux;
  logic              rsp_hs;

  // last_q names the previous winner; on contention the other requester wins.
  always_comb begin
    idle        = (state_q == IDLE);
    grant0      = r0_valid & (~r1_valid | last_q);
    grant1      = r1_valid & (~r0_valid | ~last_q);
    r0_ready    = idle & grant0;
    r1_ready    = idle & grant1;
    accept      = r0_ready | r1_ready;
    sel         = r1_ready;
    sel_op      = sel ? r1_op  : r0_op;
    sel_a       = sel ? r1_a   : r0_a;
    sel_b       = sel ? r1_b   : r0_b;
    sel_aux     = sel ? r1_aux : r0_aux;
    sel_illegal = (sel_op > 4'hA);
    rsp_valid   = (state_q == RESP);
    rsp_hs      = rsp_valid & rsp_ready;
    busy        = ~idle;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = sel_illegal ? RESP : EXEC;
      EXEC: state_d = CAPT;
      CAPT: state_d = RESP;
      RESP: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      alu_sub_start <= '0;
      alu_sub_len   <= '0;
      alu_shift_amt <= '0;
      rsp_id        <= 1'b0;
      rsp_data      <= '0;
      rsp_ovf       <= 1'b0;
      rsp_err       <= 1'b0;
      ops_done      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a         <= sel_a;
        alu_b         <= sel_b;
        alu_op        <= sel_op;
        alu_sub_start <= sel_aux[17:12];
        alu_sub_len   <= sel_aux[11:6];
        alu_shift_amt <= sel_aux[5:0];
        rsp_id        <= sel;
        last_q        <= sel;
        // Illegal ops skip the ALU and answer directly with an error.
        if (sel_illegal) begin
          rsp_data <= '0;
          rsp_ovf  <= 1'b0;
          rsp_err  <= 1'b1;
        end
      end
      if (state_q == CAPT) begin
        rsp_data <= alu_o;
        rsp_ovf  <= alu_overflow;
        rsp_err  <= 1'b0;
      end
      if (rsp_hs && (ops_done != {CNT_W{1'b1}})) begin
        ops_done <= ops_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: vector table plus multi-cycle corner sequences,
// with a small registered ALU model standing in for the shared ALU.
module tb_alu_req_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned NVEC   = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r0_valid, r1_valid, r0_ready, r1_ready;
  logic [3:0]        r0_op, r1_op, alu_op;
  logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_o, rsp_data;
  logic [17:0]       r0_aux, r1_aux;
  logic [5:0]        alu_sub_start, alu_sub_len, alu_shift_amt;
  logic              alu_overflow, rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err, busy;
  logic [CNT_W-1:0]  ops_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [17:0] aux;
    logic [63:0] d;
    logic        ovf;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  alu_req_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_aux(r0_aux),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_aux(r1_aux),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sub_start(alu_sub_start),
    .alu_sub_len(alu_sub_len), .alu_shift_amt(alu_shift_amt),
    .alu_o(alu_o), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
  );

  // ALU stand-in: add with carry, subtract with borrow, xor otherwise; registered output.
  initial begin
    alu_o        = '0;
    alu_overflow = 1'b0;
  end
  always @(posedge clk) begin
    case (alu_op)
      4'h0:    {alu_overflow, alu_o} <= {1'b0, alu_a} + {1'b0, alu_b};
      4'h1:    {alu_overflow, alu_o} <= {1'b0, alu_a} - {1'b0, alu_b};
      default: {alu_overflow, alu_o} <= {1'b0, alu_a ^ alu_b};
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bump_done();
    if (exp_done < (1 << CNT_W) - 1) exp_done++;
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    int lat;
    logic rdy;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (v.who) begin
      r1_valid = 1'b1; r1_op = v.op; r1_a = v.a; r1_b = v.b; r1_aux = v.aux;
    end else begin
      r0_valid = 1'b1; r0_op = v.op; r0_a = v.a; r0_b = v.b; r0_aux = v.aux;
    end
    #1;
    w = 0;
    rdy = v.who ? r1_ready : r0_ready;
    while (!rdy && w < 10) begin
      @(negedge clk); #1;
      w++;
      rdy = v.who ? r1_ready : r0_ready;
    end
    chk("grant", rdy, 1'b1);
    chk("ready_excl", r0_ready & r1_ready, 1'b0);
    if (!rdy) begin
      r0_valid = 1'b0; r1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !v.err) begin
        chk("alu_a", alu_a, v.a);
        chk("alu_b", alu_b, v.b);
        chk("alu_op", alu_op, v.op);
        chk("alu_aux", {alu_sub_start, alu_sub_len, alu_shift_amt}, v.aux);
        chk("exec_busy", busy, 1'b1);
      end
    end while (!rsp_valid && lat < 10);
    chk("latency", lat, v.lat);
    chk("rsp_id", rsp_id, v.who);
    chk("rsp_data", rsp_data, v.d);
    chk("rsp_ovf", rsp_ovf, v.ovf);
    chk("rsp_err", rsp_err, v.err);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    bump_done();
    @(negedge clk);
    chk("ops_done", ops_done, exp_done);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int n_rsp;
    int cyc;
    vecs[0] = '{1'b0, 4'h0, 64'd5, 64'd7, {6'd5, 6'd9, 6'd33}, 64'd12, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 18'h0, 64'd0, 1'b1, 1'b0, 3};
    vecs[2] = '{1'b0, 4'hC, 64'd123, 64'd4, 18'h0, 64'd0, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b0, 4'h0, 64'd10, 64'd20, {6'd63, 6'd0, 6'd1}, 64'd30, 1'b0, 1'b0, 3};
    vecs[4] = '{1'b1, 4'h1, 64'd9, 64'd4, 18'h0, 64'd5, 1'b0, 1'b0, 3};
    vecs[5] = '{1'b1, 4'h1, 64'd3, 64'd5, 18'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 3};
    vecs[6] = '{1'b1, 4'hB, 64'd1, 64'd1, 18'h0, 64'd0, 1'b0, 1'b1, 1};
    vecs[7] = '{1'b0, 4'hA, 64'hF0, 64'h0F, 18'h0, 64'hFF, 1'b0, 1'b0, 3};
    vecs[8] = '{1'b0, 4'hF, 64'd2, 64'd2, 18'h0, 64'd0, 1'b0, 1'b1, 1};

    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    r0_op = '0; r1_op = '0; r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    r0_aux = '0; r1_aux = '0;
    #12;
    chk("rst_r0_ready", r0_ready, 1'b0);
    chk("rst_r1_ready", r1_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_rsp", {rsp_id, rsp_ovf, rsp_err}, 3'b000);
    chk("rst_ops_done", ops_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Response stall with r1 waiting; r1 must only be granted after the handshake.
    @(negedge clk);
    r0_valid = 1'b1; r0_op = 4'h0; r0_a = 64'd2; r0_b = 64'd3;
    #1;
    chk("stall_grant", r0_ready, 1'b1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_op = 4'h0; r1_a = 64'd1; r1_b = 64'd1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_data, 64'd5);
      chk("stall_id", rsp_id, 1'b0);
      chk("stall_r1_ready", r1_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    bump_done();
    @(negedge clk);
    chk("stall_done", ops_done, exp_done);
    chk("stall_r1_next", r1_ready, 1'b1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_r1_rsp", {rsp_valid, rsp_id}, 2'b11);
    chk("stall_r1_data", rsp_data, 64'd2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while EXEC: everything clears at once and no response follows.
    @(negedge clk);
    r0_valid = 1'b1; r0_op = 4'h0; r0_a = 64'd7; r0_b = 64'd8;
    #1;
    chk("mid_grant", r0_ready, 1'b1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_done = 0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_alu_a", alu_a, 64'd0);
    chk("mid_alu_b", alu_b, 64'd0);
    chk("mid_rsp_data", rsp_data, 64'd0);
    chk("mid_ops_done", ops_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {rsp_valid, busy}, 2'b00);
    end

    // Both requesters held valid: grants alternate starting with r0.
    r0_valid = 1'b1; r0_op = 4'h0; r0_a = 64'd1; r0_b = 64'd1;
    r1_valid = 1'b1; r1_op = 4'h1; r1_a = 64'd9; r1_b = 64'd4;
    rsp_ready = 1'b1;
    #1;
    chk("rr_first", {r0_ready, r1_ready}, 2'b10);
    n_rsp = 0;
    cyc = 0;
    while (n_rsp < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk("rr_excl", r0_ready & r1_ready, 1'b0);
      if (rsp_valid) begin
        chk("rr_id", rsp_id, n_rsp % 2);
        chk("rr_data", rsp_data, (n_rsp % 2) ? 64'd5 : 64'd2);
        bump_done();
        n_rsp++;
        if (n_rsp == 4) begin
          r0_valid = 1'b0;
          r1_valid = 1'b0;
        end
      end
    end
    chk("rr_count", n_rsp, 4);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rr_done", ops_done, exp_done);
    chk("rr_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
